// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared state encoding, LFSR step and bus constants for mem_test_master.
package mem_test_pkg;
  typedef enum logic [1:0] {MT_IDLE, MT_WRITE, MT_READ, MT_DONE} mt_state_t;
  localparam logic [1:0] MT_BYTESEL_ALL = 2'b11;
  function automatic logic [15:0] lfsr16_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with synchronous load and step enable.
module lfsr16
  import mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o
);
  logic [15:0] value_q;
  always_ff @(posedge clk)
    value_q <= reset ? 16'h0 : load_i ? seed_i : en_i ? lfsr16_next(value_q) : value_q;
  assign value_o = value_q;
endmodule

// File: rtl/mem_test_master.sv
// mem_test_master: fills a word range with an LFSR pattern over the m_access/m_ack bus, reads it back and counts mismatches.
module mem_test_master
  import mem_test_pkg::*;
#(
  parameter logic [18:0] START_ADDR = 19'h0,
  parameter logic [19:0] NUM_WORDS  = 20'h400,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [18:0] m_addr,
  output logic [15:0] m_data_out,
  input  logic [15:0] m_data_in,
  output logic        m_access,
  input  logic        m_ack,
  output logic        m_wr_en,
  output logic [1:0]  m_bytesel,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [18:0] first_fail_addr
);
  mt_state_t   state_q;
  logic [18:0] addr_q, ffa_q;
  logic [19:0] cnt_q;
  logic [15:0] err_q, err_d, lfsr_val;
  logic        access_q, wr_en_q, busy_q, done_q, pass_q;
  logic        acc_ack, last, idle, mismatch, lfsr_load;
  always_comb begin
    acc_ack   = access_q & m_ack;
    last      = cnt_q == 20'd1;
    idle      = (state_q == MT_IDLE) || (state_q == MT_DONE);
    mismatch  = m_data_in != lfsr_val;
    err_d     = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    lfsr_load = (idle & start) | ((state_q == MT_WRITE) & acc_ack & last);
  end
  // The LFSR register doubles as the write-data output; it only moves on an accepted ack.
  lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (lfsr_load),
    .en_i   (acc_ack),
    .seed_i (SEED),
    .value_o(lfsr_val)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MT_IDLE;
      addr_q   <= 19'h0;
      cnt_q    <= 20'h0;
      access_q <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'h0;
      ffa_q    <= 19'h0;
    end else begin
      case (state_q)
        MT_IDLE, MT_DONE: if (start) begin
          err_q  <= 16'h0;
          ffa_q  <= 19'h0;
          addr_q <= START_ADDR;
          cnt_q  <= NUM_WORDS;
          if (NUM_WORDS == 20'd0) begin
            state_q <= MT_DONE;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            state_q  <= MT_WRITE;
            access_q <= 1'b1;
            wr_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        // access_q low inside WRITE/READ is the mandatory gap cycle after an ack.
        MT_WRITE: if (!access_q) access_q <= 1'b1;
        else if (m_ack) begin
          access_q <= 1'b0;
          if (last) begin
            state_q <= MT_READ;
            wr_en_q <= 1'b0;
            addr_q  <= START_ADDR;
            cnt_q   <= NUM_WORDS;
          end else begin
            addr_q <= addr_q + 19'd1;
            cnt_q  <= cnt_q - 20'd1;
          end
        end
        MT_READ: if (!access_q) access_q <= 1'b1;
        else if (m_ack) begin
          access_q <= 1'b0;
          err_q    <= err_d;
          if (mismatch && err_q == 16'h0) ffa_q <= addr_q;
          if (last) begin
            state_q <= MT_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= err_d == 16'h0;
          end else begin
            addr_q <= addr_q + 19'd1;
            cnt_q  <= cnt_q - 20'd1;
          end
        end
      endcase
    end
  end
  assign m_addr          = addr_q;
  assign m_data_out      = lfsr_val;
  assign m_access        = access_q;
  assign m_wr_en         = wr_en_q;
  assign m_bytesel       = MT_BYTESEL_ALL;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;
endmodule
